// File: rtl/openmips_rst_seq.sv
// Staggered reset sequencer with run-length counter for the OpenMIPS SOPC.
// Optional RSTSEQ_STOP_EN: simulation-only message and $stop when run_done rises.
module openmips_rst_seq #(
  parameter int CHANNELS    = 4,
  parameter int HOLD_CYCLES = 10,
  parameter int STAGGER     = 2,
  parameter int RUN_CYCLES  = 50,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                soft_rst_req,
  output logic [CHANNELS-1:0] rst_out,
  output logic                all_released,
  output logic                run_done,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [1:0]          state
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int SW = $clog2(STAGGER) + 1;
  localparam int IW = $clog2(CHANNELS) + 1;

  localparam logic [HW-1:0]       HOLD_END = HW'(HOLD_CYCLES);
  localparam logic [SW-1:0]       STG_END  = SW'(STAGGER);
  localparam logic [IW-1:0]       LAST_IDX = IW'(CHANNELS - 1);
  localparam logic [CNT_W-1:0]    RUN_END  = CNT_W'(RUN_CYCLES);
  localparam logic [CHANNELS-1:0] CH0_MASK = CHANNELS'(1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        fsm;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] stg_cnt;
  logic [IW-1:0] idx;

  assign state = fsm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm          <= HOLD;
      hold_cnt     <= '0;
      stg_cnt      <= '0;
      idx          <= '0;
      rst_out      <= '1;
      all_released <= 1'b0;
      run_done     <= 1'b0;
      cycle_cnt    <= '0;
    end else if (soft_rst_req) begin
      // A restart request overrides every transition and counts as edge 0.
      fsm          <= HOLD;
      hold_cnt     <= '0;
      stg_cnt      <= '0;
      idx          <= '0;
      rst_out      <= '1;
      all_released <= 1'b0;
      run_done     <= 1'b0;
      cycle_cnt    <= '0;
    end else begin
      case (fsm)
        HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt + 1'b1 == HOLD_END) begin
            fsm     <= RELEASE;
            stg_cnt <= '0;
            idx     <= '0;
          end
        end
        RELEASE: begin
          if (stg_cnt + 1'b1 == STG_END) begin
            stg_cnt <= '0;
            rst_out <= rst_out & ~(CH0_MASK << idx);
            idx     <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              all_released <= 1'b1;
              fsm          <= RUN;
            end
          end else begin
            stg_cnt <= stg_cnt + 1'b1;
          end
        end
        RUN: begin
          if (cycle_cnt != '1)
            cycle_cnt <= cycle_cnt + 1'b1;
          // RUN_CYCLES of zero means run forever with a saturating count.
          if (RUN_CYCLES != 0 && cycle_cnt + 1'b1 == RUN_END) begin
            run_done <= 1'b1;
            fsm      <= DONE;
`ifdef RSTSEQ_STOP_EN
            $display("openmips_rst_seq: run complete, cycle_cnt=%0d", RUN_CYCLES);
            $stop;
`endif
          end
        end
        DONE: begin
        end
        default: fsm <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_openmips_rst_seq.sv
// Randomised bench: two sequencer configurations checked against an edge-count timing model.
module tb_openmips_rst_seq;

  logic        clk;
  logic        rst;
  logic        soft_rst_req;
  logic [3:0]  d_rst_out;
  logic        d_all_released;
  logic        d_run_done;
  logic [15:0] d_cycle_cnt;
  logic [1:0]  d_state;
  logic [0:0]  s_rst_out;
  logic        s_all_released;
  logic        s_run_done;
  logic [3:0]  s_cycle_cnt;
  logic [1:0]  s_state;

  int total = 0;
  int bad   = 0;
  int e     = 0;  // edges since sequence start; 0 while in reset
  int soft_left = 0;

  openmips_rst_seq dut (
    .clk(clk), .rst(rst), .soft_rst_req(soft_rst_req),
    .rst_out(d_rst_out), .all_released(d_all_released), .run_done(d_run_done),
    .cycle_cnt(d_cycle_cnt), .state(d_state)
  );

  openmips_rst_seq #(
    .CHANNELS(1), .HOLD_CYCLES(1), .STAGGER(1), .RUN_CYCLES(0), .CNT_W(4)
  ) dut_small (
    .clk(clk), .rst(rst), .soft_rst_req(soft_rst_req),
    .rst_out(s_rst_out), .all_released(s_all_released), .run_done(s_run_done),
    .cycle_cnt(s_cycle_cnt), .state(s_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at e=%0d: got %0h want %0h", tag, e, obs, exp);
    end
  endtask

  // Expected outputs straight from the timing rules, as a function of edge count.
  function automatic int rel_edge(int h, int s, int c);
    return h + c * s;
  endfunction

  function automatic int exp_rst_out(int n, int h, int s, int c);
    int v = 0;
    for (int k = 0; k < c; k++)
      if (n < h + (k + 1) * s) v |= (1 << k);
    return v;
  endfunction

  function automatic int exp_cnt(int n, int h, int s, int c, int r, int maxv);
    int v = 0;
    if (n > rel_edge(h, s, c)) v = n - rel_edge(h, s, c);
    if (r != 0 && v > r) v = r;
    if (v > maxv) v = maxv;
    return v;
  endfunction

  function automatic int exp_done(int n, int h, int s, int c, int r);
    return (r != 0 && n >= rel_edge(h, s, c) + r) ? 1 : 0;
  endfunction

  function automatic int exp_state(int n, int h, int s, int c, int r);
    if (n < h) return 0;
    if (n < rel_edge(h, s, c)) return 1;
    if (r == 0 || n < rel_edge(h, s, c) + r) return 2;
    return 3;
  endfunction

  task automatic check_all();
    check("d.rst_out",  32'(d_rst_out),      32'(exp_rst_out(e, 10, 2, 4)));
    check("d.all_rel",  32'(d_all_released), 32'(e >= rel_edge(10, 2, 4)));
    check("d.run_done", 32'(d_run_done),     32'(exp_done(e, 10, 2, 4, 50)));
    check("d.cnt",      32'(d_cycle_cnt),    32'(exp_cnt(e, 10, 2, 4, 50, 65535)));
    check("d.state",    32'(d_state),        32'(exp_state(e, 10, 2, 4, 50)));
    check("s.rst_out",  32'(s_rst_out),      32'(exp_rst_out(e, 1, 1, 1)));
    check("s.all_rel",  32'(s_all_released), 32'(e >= rel_edge(1, 1, 1)));
    check("s.run_done", 32'(s_run_done),     32'(exp_done(e, 1, 1, 1, 0)));
    check("s.cnt",      32'(s_cycle_cnt),    32'(exp_cnt(e, 1, 1, 1, 0, 15)));
    check("s.state",    32'(s_state),        32'(exp_state(e, 1, 1, 1, 0)));
  endtask

  // One clock edge: advance the model with the inputs seen at that edge, then sample.
  task automatic step();
    @(posedge clk);
    if (rst || soft_rst_req) e = 0;
    else e++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    soft_rst_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Undisturbed run: release, DONE at edge 68, frozen afterwards; small config saturates.
    for (int i = 0; i < 90; i++) step();
    $display("directed run complete at e=%0d", e);

    for (int i = 0; i < 900; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (soft_left > 0) begin
        soft_left--;
        soft_rst_req = (soft_left > 0);
      end else if (r < 2) begin
        soft_left = int'($urandom_range(1, 4));
        soft_rst_req = 1'b1;
        $display("soft_rst_req for %0d edges at e=%0d", soft_left, e);
      end else begin
        soft_rst_req = 1'b0;
      end

      if (rst && r >= 40) begin
        rst = 1'b0;
        $display("rst released");
      end else if (!rst && r == 3) begin
        // Asynchronous assertion mid-cycle: outputs must reset before the next edge.
        #2 rst = 1'b1;
        #1 e = 0;
        $display("async rst asserted mid-cycle");
        check_all();
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
